// File: rtl/zrd_pkg.sv
// Shared defaults and helpers for the zero_run_detect slice.
// Optional build macro: ZRD_STICKY_ALARM_EN (see zrd_channel).
package zrd_pkg;

    localparam int unsigned ZRD_WIDTH    = 4;
    localparam int unsigned ZRD_CHANNELS = 4;
    localparam int unsigned ZRD_CNT_W    = 8;

    // Increment that stops at 2**cnt_w-1 instead of wrapping (cnt_w <= 31).
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned cnt_w);
        logic [32:0] max_cnt;
        max_cnt = (33'd1 << cnt_w) - 33'd1;
        if ({1'b0, cnt} >= max_cnt) begin
            return cnt;
        end
        return cnt + 32'd1;
    endfunction

endpackage

// File: rtl/zero_run_detect_if.sv
// Sample-in / status-out bundle for zero_run_detect.
interface zero_run_detect_if
    import zrd_pkg::*;
#(
    parameter int unsigned WIDTH    = ZRD_WIDTH,
    parameter int unsigned CHANNELS = ZRD_CHANNELS,
    parameter int unsigned CNT_W    = ZRD_CNT_W
);

    logic                         in_valid;
    logic [CHANNELS*WIDTH-1:0]    in_data;
    logic [CNT_W-1:0]             threshold;
    logic                         clear;
    logic                         out_valid;
    logic [CHANNELS-1:0]          zero_flag;
    logic [CHANNELS*CNT_W-1:0]    run_len;
    logic [CHANNELS-1:0]          alarm;

    modport master (
        output in_valid, in_data, threshold, clear,
        input  out_valid, zero_flag, run_len, alarm
    );

    modport slave (
        input  in_valid, in_data, threshold, clear,
        output out_valid, zero_flag, run_len, alarm
    );

endinterface

// File: rtl/zrd_channel.sv
// One lane: zero compare, saturating run counter and alarm register.
// ZRD_STICKY_ALARM_EN: alarm latches until rst/clear instead of following the run.
module zrd_channel
    import zrd_pkg::*;
#(
    parameter int unsigned WIDTH = ZRD_WIDTH,
    parameter int unsigned CNT_W = ZRD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic             clear,
    input  logic [WIDTH-1:0] sample,
    input  logic [CNT_W-1:0] threshold,
    output logic             zero_flag,
    output logic [CNT_W-1:0] run_len,
    output logic             alarm
);

    logic             is_zero_c;
    logic [CNT_W-1:0] run_len_nxt_c;
    logic             alarm_cond_c;
    logic             alarm_nxt_c;

    // Next-state for an accepted sample; alarm compares against the new run length.
    always_comb begin
        is_zero_c     = (sample == '0);
        run_len_nxt_c = '0;
        if (is_zero_c) begin
            run_len_nxt_c = CNT_W'(sat_inc(32'(run_len), CNT_W));
        end
        alarm_cond_c = (threshold != '0) && (run_len_nxt_c >= threshold);
`ifdef ZRD_STICKY_ALARM_EN
        alarm_nxt_c = alarm | alarm_cond_c;
`else
        alarm_nxt_c = alarm_cond_c;
`endif
    end

    // Reset beats clear, clear beats a sample; idle cycles hold state.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_flag <= 1'b0;
            run_len   <= '0;
            alarm     <= 1'b0;
        end else if (clear) begin
            zero_flag <= 1'b0;
            run_len   <= '0;
            alarm     <= 1'b0;
        end else if (sample_valid) begin
            zero_flag <= is_zero_c;
            run_len   <= run_len_nxt_c;
            alarm     <= alarm_nxt_c;
        end
    end

endmodule

// File: rtl/zero_run_detect.sv
// Multi-channel zero detector with per-channel run-length tracking and alarm.
// Build option ZRD_STICKY_ALARM_EN selects latched alarms (default: follow the run).
module zero_run_detect
    import zrd_pkg::*;
#(
    parameter int unsigned WIDTH    = ZRD_WIDTH,
    parameter int unsigned CHANNELS = ZRD_CHANNELS,
    parameter int unsigned CNT_W    = ZRD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    zero_run_detect_if.slave bus
);

    // out_valid marks cycles where a sample was actually absorbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid & ~bus.clear;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        zrd_channel #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .sample_valid (bus.in_valid),
            .clear        (bus.clear),
            .sample       (bus.in_data[c*WIDTH +: WIDTH]),
            .threshold    (bus.threshold),
            .zero_flag    (bus.zero_flag[c]),
            .run_len      (bus.run_len[c*CNT_W +: CNT_W]),
            .alarm        (bus.alarm[c])
        );
    end

endmodule

// File: tb/tb_zero_run_detect.sv
// Directed, table-driven bench for zero_run_detect (8-bit and 4-bit counter builds).
module tb_zero_run_detect;

`ifdef ZRD_STICKY_ALARM_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic clk;
    logic rst;
    int   passed;
    int   total;

    zero_run_detect_if #(.WIDTH(4), .CHANNELS(4), .CNT_W(8)) b8 ();
    zero_run_detect_if #(.WIDTH(4), .CHANNELS(4), .CNT_W(4)) b4 ();

    zero_run_detect #(.WIDTH(4), .CHANNELS(4), .CNT_W(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    zero_run_detect #(.WIDTH(4), .CHANNELS(4), .CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4)
    );

    // Narrow-counter instance shadows the main stimulus with alarms disabled.
    assign b4.in_valid  = b8.in_valid;
    assign b4.in_data   = b8.in_data;
    assign b4.clear     = b8.clear;
    assign b4.threshold = 4'd0;

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        clr;
        logic [7:0]  thr;
        logic [15:0] data;
        logic        exp_ov;
        logic [3:0]  exp_zf;
        logic [31:0] exp_rl;
        logic [3:0]  exp_al;
    } vec_t;

    localparam int NV = 16;
    vec_t vec [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic check_all8(input string tag, input logic ov, input logic [3:0] zf,
                              input logic [31:0] rl, input logic [3:0] al);
        check({tag, " out_valid"}, 64'(b8.out_valid), 64'(ov));
        check({tag, " zero_flag"}, 64'(b8.zero_flag), 64'(zf));
        check({tag, " run_len"},   64'(b8.run_len),   64'(rl));
        check({tag, " alarm"},     64'(b8.alarm),     64'(al));
    endtask

    initial begin
        logic [7:0] e8;
        logic [3:0] e4;

        clk = 1'b0;
        passed = 0;
        total = 0;

        // valid, clr, thr, data | out_valid, zero_flag, run_len, alarm
        vec[0]  = '{1'b1, 1'b0, 8'd3, 16'hFFF0, 1'b1, 4'h1, 32'h0000_0001, 4'h0};
        vec[1]  = '{1'b1, 1'b0, 8'd3, 16'hFFF0, 1'b1, 4'h1, 32'h0000_0002, 4'h0};
        vec[2]  = '{1'b1, 1'b0, 8'd3, 16'hFFF0, 1'b1, 4'h1, 32'h0000_0003, 4'h1};
        vec[3]  = '{1'b1, 1'b0, 8'd3, 16'hFFF5, 1'b1, 4'h0, 32'h0000_0000, STICKY ? 4'h1 : 4'h0};
        vec[4]  = '{1'b1, 1'b0, 8'd3, 16'hF0FF, 1'b1, 4'h4, 32'h0001_0000, STICKY ? 4'h1 : 4'h0};
        vec[5]  = '{1'b0, 1'b0, 8'd3, 16'h0000, 1'b0, 4'h4, 32'h0001_0000, STICKY ? 4'h1 : 4'h0};
        vec[6]  = '{1'b0, 1'b0, 8'd3, 16'h0000, 1'b0, 4'h4, 32'h0001_0000, STICKY ? 4'h1 : 4'h0};
        vec[7]  = '{1'b1, 1'b0, 8'd3, 16'hF0FF, 1'b1, 4'h4, 32'h0002_0000, STICKY ? 4'h1 : 4'h0};
        vec[8]  = '{1'b1, 1'b1, 8'd3, 16'h0000, 1'b0, 4'h0, 32'h0000_0000, 4'h0};
        vec[9]  = '{1'b1, 1'b0, 8'd3, 16'h0000, 1'b1, 4'hF, 32'h0101_0101, 4'h0};
        vec[10] = '{1'b1, 1'b0, 8'd3, 16'h0000, 1'b1, 4'hF, 32'h0202_0202, 4'h0};
        vec[11] = '{1'b1, 1'b0, 8'd3, 16'h0000, 1'b1, 4'hF, 32'h0303_0303, 4'hF};
        vec[12] = '{1'b1, 1'b0, 8'd3, 16'h5000, 1'b1, 4'h7, 32'h0004_0404, STICKY ? 4'hF : 4'h7};
        vec[13] = '{1'b1, 1'b0, 8'd5, 16'h0000, 1'b1, 4'hF, 32'h0105_0505, STICKY ? 4'hF : 4'h7};
        vec[14] = '{1'b0, 1'b0, 8'd5, 16'h0000, 1'b0, 4'hF, 32'h0105_0505, STICKY ? 4'hF : 4'h7};
        vec[15] = '{1'b0, 1'b1, 8'd5, 16'h0000, 1'b0, 4'h0, 32'h0000_0000, 4'h0};

        // Reset held two cycles under random traffic
        rst = 1'b1;
        b8.clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b8.in_valid  = 1'($urandom);
            b8.in_data   = 16'($urandom);
            b8.threshold = 8'($urandom);
            tick();
            check_all8($sformatf("reset%0d", i), 1'b0, 4'h0, 32'h0, 4'h0);
        end
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            b8.in_valid  = vec[i].valid;
            b8.clear     = vec[i].clr;
            b8.threshold = vec[i].thr;
            b8.in_data   = vec[i].data;
            tick();
            check_all8($sformatf("vec%0d", i), vec[i].exp_ov, vec[i].exp_zf,
                       vec[i].exp_rl, vec[i].exp_al);
        end

        // 4-bit counter on ch1: saturates at 15, no wrap
        b8.clear = 1'b0;
        b8.in_valid = 1'b1;
        b8.in_data = 16'hFF0F;
        for (int i = 0; i < 20; i++) begin
            tick();
            e4 = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            check($sformatf("sat4 s%0d run_len", i), 64'(b4.run_len), 64'({8'h00, e4, 4'h0}));
        end
        check("sat4 ref8 run_len", 64'(b8.run_len), 64'(32'h0000_1400));

        b8.clear = 1'b1;
        tick();
        check_all8("clr_idle", 1'b0, 4'h0, 32'h0, 4'h0);
        b8.clear = 1'b0;

        // Threshold 0: long all-zero run, 8-bit saturation, no alarm
        b8.threshold = 8'd0;
        b8.in_data = 16'h0000;
        for (int i = 0; i < 300; i++) begin
            tick();
            e8 = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            check($sformatf("thr0 s%0d run_len", i), 64'(b8.run_len), 64'({4{e8}}));
            check($sformatf("thr0 s%0d alarm", i), 64'(b8.alarm), 64'(0));
        end
        check("thr0 zero_flag", 64'(b8.zero_flag), 64'(4'hF));
        check("thr0 b4 run_len", 64'(b4.run_len), 64'(16'hFFFF));

        // Reset mid-run wins over a valid zero sample
        b8.threshold = 8'd1;
        rst = 1'b1;
        tick();
        check_all8("rst_mid", 1'b0, 4'h0, 32'h0, 4'h0);
        check("rst_mid b4 run_len", 64'(b4.run_len), 64'(0));
        rst = 1'b0;
        b8.in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
